// File: rtl/ccl_pkg.sv
// Shared types and constants for the connected-components label resolver.
package ccl_pkg;

  localparam int unsigned LABEL_W_DEF = 8;
  localparam int unsigned BACKGROUND  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FLATTEN,
    ST_DONE
  } ccl_state_e;

  // Merge pair at the default label width; hi is always the larger label.
  typedef struct packed {
    logic [LABEL_W_DEF-1:0] hi;
    logic [LABEL_W_DEF-1:0] lo;
  } merge_pair_t;

endpackage

// File: rtl/ccl_merge_fifo.sv
// Synchronous merge-pair FIFO: one pop and one push per cycle, where a push
// carries up to two entries (push0 is written ahead of push1).
module ccl_merge_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push0,
  input  logic [WIDTH-1:0]         din0,
  input  logic                     push1,
  input  logic [WIDTH-1:0]         din1,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] slot1;

  assign slot1 = wr_ptr_q + PTR_W'(push0);
  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage writes; the second entry lands directly behind the first.
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_ptr_q] <= din0;
    if (push1) mem_q[slot1]    <= din1;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count    <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/ccl_merge_resolver.sv
// Label-equivalence engine: allocates labels, resolves merge pairs into a
// union-find table, flattens it at end of frame and serves final labels.
// Optional statistics (merge_count, fifo_hwm) are built when
// CCL_MERGE_STATS_EN is defined; otherwise those ports read 0.
module ccl_merge_resolver
  import ccl_pkg::*;
#(
  parameter int unsigned LABEL_W    = LABEL_W_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_start,
  input  logic                          alloc_valid,
  output logic [LABEL_W-1:0]            alloc_label,
  input  logic                          merge_valid,
  input  logic [LABEL_W-1:0]            merge_a,
  input  logic [LABEL_W-1:0]            merge_b,
  output logic                          merge_ready,
  input  logic                          eof,
  input  logic [LABEL_W-1:0]            lookup_label,
  output logic [LABEL_W-1:0]            lookup_root,
  output logic                          flatten_done,
  output logic [LABEL_W-1:0]            num_labels,
  output logic                          busy,
  output logic                          label_exhausted,
  output logic                          proto_err,
  output logic [15:0]                   merge_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_hwm
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PAIR_W  = 2 * LABEL_W;
  localparam int unsigned NUM_ENT = 1 << LABEL_W;
  localparam logic [LABEL_W-1:0] MAX_LABEL   = '1;
  localparam logic [LABEL_W-1:0] BG          = LABEL_W'(BACKGROUND);
  localparam logic [CNT_W-1:0]   READY_LIMIT = CNT_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [LABEL_W-1:0] hi;
    logic [LABEL_W-1:0] lo;
  } pair_t;

  logic [LABEL_W-1:0] table_q [NUM_ENT];

  ccl_state_e         state_q;
  logic               st_run;
  logic               eng_active;
  logic               alloc_we;
  logic               err_c;
  logic               fs_acc;

  pair_t              ext_pair;
  logic               ext_push;
  pair_t              fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               eng_busy_q;
  pair_t              pair_q;
  logic [LABEL_W-1:0] t_q;
  logic               eng_pop;
  logic               eng_need_wr;
  logic               eng_reenq;
  logic               eng_stall;
  logic               eng_fire;
  logic               eng_wr;
  logic               reenq_push;
  pair_t              reenq_pair;

  logic [LABEL_W-1:0] flat_idx_q;
  logic               flat_rd_q;
  logic [LABEL_W-1:0] flat_t_q;
  logic               flat_wr;

  logic               mem_we;
  logic [LABEL_W-1:0] mem_wa;
  logic [LABEL_W-1:0] mem_wd;

  assign st_run     = (state_q == ST_RUN);
  assign eng_active = st_run || (state_q == ST_DRAIN);
  assign fs_acc     = frame_start && (state_q == ST_IDLE);
  assign err_c      = (alloc_valid || merge_valid) && !st_run;

  assign alloc_we    = st_run && alloc_valid && (num_labels != MAX_LABEL);
  assign alloc_label = alloc_we ? num_labels : BG;

  // One slot stays free so a re-enqueue can always land beside a push.
  assign merge_ready = st_run && !fifo_full && (fifo_count < READY_LIMIT);

  // Canonicalise the incoming pair; equal labels are accepted but dropped.
  always_comb begin
    ext_pair = '0;
    if (merge_a > merge_b) begin
      ext_pair.hi = merge_a;
      ext_pair.lo = merge_b;
    end else begin
      ext_pair.hi = merge_b;
      ext_pair.lo = merge_a;
    end
  end

  assign ext_push = merge_valid && merge_ready && (merge_a != merge_b);

  // Engine decode for the WRITE phase of the pair held in pair_q.
  always_comb begin
    reenq_pair = '0;
    if (t_q < pair_q.lo) begin
      reenq_pair.hi = pair_q.lo;
      reenq_pair.lo = t_q;
    end else begin
      reenq_pair.hi = t_q;
      reenq_pair.lo = pair_q.lo;
    end
  end

  assign eng_need_wr = (t_q >= pair_q.lo);
  assign eng_reenq   = (t_q != pair_q.hi) && (t_q != pair_q.lo);
  assign eng_pop     = eng_active && !eng_busy_q && !fifo_empty;
  assign eng_stall   = eng_busy_q && eng_need_wr && alloc_we;
  assign eng_fire    = eng_busy_q && !eng_stall;
  assign eng_wr      = eng_fire && eng_need_wr;
  assign reenq_push  = eng_fire && eng_reenq;

  assign flat_wr = (state_q == ST_FLATTEN) && flat_rd_q;

  ccl_merge_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push0   (reenq_push),
    .din0    (reenq_pair),
    .push1   (ext_push),
    .din1    (ext_pair),
    .pop     (eng_pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Table write-port arbitration: allocation, then engine, then flatten.
  always_comb begin
    mem_we = alloc_we || eng_wr || flat_wr;
    mem_wa = '0;
    mem_wd = '0;
    if (alloc_we) begin
      mem_wa = num_labels;
      mem_wd = num_labels;
    end else if (eng_wr) begin
      mem_wa = pair_q.hi;
      mem_wd = pair_q.lo;
    end else if (flat_wr) begin
      mem_wa = flat_idx_q;
      mem_wd = table_q[flat_t_q];
    end
  end

  // Union-find table storage; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) table_q[mem_wa] <= mem_wd;
  end

  // Merge engine: READ pops a pair and samples table[hi], WRITE resolves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_busy_q <= 1'b0;
      pair_q     <= '0;
      t_q        <= '0;
    end else if (eng_pop) begin
      eng_busy_q <= 1'b1;
      pair_q     <= fifo_dout;
      t_q        <= table_q[fifo_dout.hi];
    end else if (eng_fire) begin
      eng_busy_q <= 1'b0;
    end
  end

  // Frame control FSM, allocation counter, flatten sweep and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      num_labels      <= LABEL_W'(1);
      label_exhausted <= 1'b0;
      proto_err       <= 1'b0;
      busy            <= 1'b0;
      flatten_done    <= 1'b0;
      flat_idx_q      <= '0;
      flat_rd_q       <= 1'b0;
      flat_t_q        <= '0;
    end else begin
      flatten_done <= 1'b0;
      if (err_c) proto_err <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q         <= ST_RUN;
            num_labels      <= LABEL_W'(1);
            label_exhausted <= 1'b0;
            proto_err       <= err_c;
          end
        end
        ST_RUN: begin
          if (alloc_we) begin
            num_labels <= num_labels + LABEL_W'(1);
          end else if (alloc_valid) begin
            label_exhausted <= 1'b1;
          end
          if (eof) begin
            state_q <= ST_DRAIN;
            busy    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty && !eng_busy_q) begin
            state_q    <= ST_FLATTEN;
            flat_idx_q <= LABEL_W'(1);
            flat_rd_q  <= 1'b0;
          end
        end
        ST_FLATTEN: begin
          if (!flat_rd_q) begin
            if (flat_idx_q == num_labels) begin
              state_q      <= ST_DONE;
              busy         <= 1'b0;
              flatten_done <= 1'b1;
            end else begin
              flat_t_q  <= table_q[flat_idx_q];
              flat_rd_q <= 1'b1;
            end
          end else begin
            flat_idx_q <= flat_idx_q + LABEL_W'(1);
            flat_rd_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered lookup port; background always reads as background.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lookup_root <= '0;
    end else if (lookup_label == BG) begin
      lookup_root <= BG;
    end else begin
      lookup_root <= table_q[lookup_label];
    end
  end

`ifdef CCL_MERGE_STATS_EN
  // Per-frame merge counter (saturating) and FIFO high-water mark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      merge_count <= '0;
      fifo_hwm    <= '0;
    end else if (fs_acc) begin
      merge_count <= '0;
      fifo_hwm    <= '0;
    end else begin
      if (ext_push && (merge_count != 16'hFFFF)) merge_count <= merge_count + 16'd1;
      if (fifo_count > fifo_hwm) fifo_hwm <= fifo_count;
    end
  end
`else
  assign merge_count = '0;
  assign fifo_hwm    = '0;
`endif

endmodule

// File: tb/tb_ccl_merge_resolver.sv
// Self-checking bench for ccl_merge_resolver with a union-find reference model.
module tb_ccl_merge_resolver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n      = 1'b0;
  logic       frame_start  = 1'b0;
  logic       alloc_valid  = 1'b0;
  logic       merge_valid  = 1'b0;
  logic [7:0] merge_a      = '0;
  logic [7:0] merge_b      = '0;
  logic       eof          = 1'b0;
  logic [7:0] lookup_label = '0;
  logic [7:0] alloc_label;
  logic       merge_ready;
  logic [7:0] lookup_root;
  logic       flatten_done;
  logic [7:0] num_labels;
  logic       busy;
  logic       label_exhausted;
  logic       proto_err;
  logic [15:0] merge_count;
  logic [4:0] fifo_hwm;

  logic       frame_start4 = 1'b0;
  logic       alloc_valid4 = 1'b0;
  logic [3:0] alloc_label4;
  logic       merge_ready4;
  logic [3:0] lookup_root4;
  logic       flatten_done4;
  logic [3:0] num_labels4;
  logic       busy4;
  logic       label_exhausted4;
  logic       proto_err4;
  logic [15:0] merge_count4;
  logic [4:0] fifo_hwm4;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int parent[256];
  int next_label = 1;

  ccl_merge_resolver #(.LABEL_W(8), .FIFO_DEPTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .alloc_valid(alloc_valid), .alloc_label(alloc_label),
    .merge_valid(merge_valid), .merge_a(merge_a), .merge_b(merge_b),
    .merge_ready(merge_ready), .eof(eof), .lookup_label(lookup_label),
    .lookup_root(lookup_root), .flatten_done(flatten_done),
    .num_labels(num_labels), .busy(busy), .label_exhausted(label_exhausted),
    .proto_err(proto_err), .merge_count(merge_count), .fifo_hwm(fifo_hwm)
  );

  ccl_merge_resolver #(.LABEL_W(4), .FIFO_DEPTH(16)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start4),
    .alloc_valid(alloc_valid4), .alloc_label(alloc_label4),
    .merge_valid(1'b0), .merge_a(4'd0), .merge_b(4'd0),
    .merge_ready(merge_ready4), .eof(1'b0), .lookup_label(4'd0),
    .lookup_root(lookup_root4), .flatten_done(flatten_done4),
    .num_labels(num_labels4), .busy(busy4), .label_exhausted(label_exhausted4),
    .proto_err(proto_err4), .merge_count(merge_count4), .fifo_hwm(fifo_hwm4)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int find(input int x);
    int y = x;
    while (parent[y] != y) y = parent[y];
    return y;
  endfunction

  task automatic model_union(input int a, input int b);
    int ra = find(a);
    int rb = find(b);
    if (ra < rb) parent[rb] = ra;
    else if (rb < ra) parent[ra] = rb;
  endtask

  task automatic start_frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    next_label = 1;
    for (int i = 0; i < 256; i++) parent[i] = i;
  endtask

  task automatic do_alloc(input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk); alloc_valid = 1'b1;
      exp_q.push_back(8'(next_label));
      next_label++;
      #1;
      e = exp_q.pop_front();
      checks++;
      if (alloc_label !== e) begin
        errors++;
        $display("FAIL alloc_label got %0d want %0d", alloc_label, e);
      end
    end
    @(negedge clk); alloc_valid = 1'b0;
  endtask

  task automatic do_merge(input int a, input int b);
    int w;
    @(negedge clk);
    merge_valid = 1'b1; merge_a = 8'(a); merge_b = 8'(b);
    #1; w = 0;
    while (merge_ready !== 1'b1 && w < 200) begin
      @(negedge clk); #1; w++;
    end
    checks++;
    if (merge_ready !== 1'b1) begin
      errors++;
      $display("FAIL merge_accept (%0d,%0d) ready=%b after %0d cycles want 1", a, b, merge_ready, w);
    end else begin
      model_union(a, b);
    end
    @(negedge clk); merge_valid = 1'b0;
  endtask

  task automatic end_frame(input int budget, output int took);
    int cyc;
    @(negedge clk); eof = 1'b1;
    @(negedge clk); eof = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_eof got %b want 1", busy);
    end
    cyc = 1;
    while (flatten_done !== 1'b1 && cyc < budget) begin
      @(negedge clk); cyc++;
    end
    took = cyc;
    checks++;
    if (flatten_done !== 1'b1) begin
      errors++;
      $display("FAIL flatten_done_timeout got %b want 1 within %0d cycles", flatten_done, budget);
    end
    @(negedge clk);
    checks++;
    if (flatten_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flatten_done_pulse got done=%b busy=%b want 0/0", flatten_done, busy);
    end
  endtask

  task automatic do_lookup(input int lbl);
    logic [7:0] e;
    logic [7:0] got;
    e = (lbl == 0) ? 8'd0 : 8'(find(lbl));
    exp_q.push_back(e);
    @(negedge clk); lookup_label = 8'(lbl);
    @(negedge clk); got = lookup_root;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL lookup(%0d) got %0d want %0d", lbl, got, e);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (num_labels !== 8'd1 || busy !== 1'b0 || flatten_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_core got num=%0d busy=%b done=%b want 1/0/0", num_labels, busy, flatten_done);
    end
    checks++;
    if (label_exhausted !== 1'b0 || proto_err !== 1'b0 || merge_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got exh=%b perr=%b ready=%b want 0/0/0", label_exhausted, proto_err, merge_ready);
    end
    checks++;
    if (lookup_root !== 8'd0 || alloc_label !== 8'd0 || merge_count !== 16'd0 || fifo_hwm !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs got root=%0d alloc=%0d mc=%0d hwm=%0d want 0", lookup_root, alloc_label, merge_count, fifo_hwm);
    end
  endtask

  task automatic test_no_merge();
    int took;
    start_frame();
    do_alloc(3);
    end_frame(40, took);
    checks++;
    if (took > 12) begin
      errors++;
      $display("FAIL flatten_latency got %0d cycles want <= 12", took);
    end
    for (int i = 0; i <= 3; i++) do_lookup(i);
  endtask

  task automatic test_proto_err();
    int took;
    @(negedge clk); alloc_valid = 1'b1; merge_valid = 1'b1; merge_a = 8'd1; merge_b = 8'd2;
    #1;
    checks++;
    if (alloc_label !== 8'd0 || merge_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_reject got alloc=%0d ready=%b want 0/0", alloc_label, merge_ready);
    end
    @(negedge clk); alloc_valid = 1'b0; merge_valid = 1'b0;
    #1;
    checks++;
    if (proto_err !== 1'b1 || num_labels !== 8'd4) begin
      errors++;
      $display("FAIL proto_err_set got perr=%b num=%0d want 1/4", proto_err, num_labels);
    end
    start_frame();
    #1;
    checks++;
    if (proto_err !== 1'b0 || num_labels !== 8'd1) begin
      errors++;
      $display("FAIL frame_start_clear got perr=%b num=%0d want 0/1", proto_err, num_labels);
    end
    end_frame(20, took);
  endtask

  task automatic test_chain();
    int took;
    start_frame();
    do_alloc(4);
    do_merge(4, 3);
    do_merge(3, 2);
    do_merge(2, 1);
    do_merge(2, 2);
    end_frame(100, took);
    for (int i = 1; i <= 4; i++) do_lookup(i);
`ifdef CCL_MERGE_STATS_EN
    checks++;
    if (merge_count !== 16'd3) begin
      errors++;
      $display("FAIL chain_merge_count got %0d want 3", merge_count);
    end
`endif
  endtask

  task automatic test_conflict();
    int took;
    start_frame();
    do_alloc(5);
    do_merge(5, 2);
    do_merge(3, 5);
    end_frame(100, took);
    for (int i = 1; i <= 5; i++) do_lookup(i);
`ifdef CCL_MERGE_STATS_EN
    checks++;
    if (merge_count !== 16'd2) begin
      errors++;
      $display("FAIL conflict_merge_count got %0d want 2", merge_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int took;
    int k;
    logic [7:0] e;
    start_frame();
    do_alloc(17);
    k = 0;
    for (int it = 0; it < 24; it++) begin
      @(negedge clk);
      alloc_valid = 1'b1;
      exp_q.push_back(8'(next_label));
      next_label++;
      merge_valid = 1'b1; merge_a = 8'(k + 2); merge_b = 8'(k + 1);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (alloc_label !== e) begin
        errors++;
        $display("FAIL stall_alloc_label got %0d want %0d", alloc_label, e);
      end
      if (merge_ready === 1'b1) begin
        model_union(k + 2, k + 1);
        k++;
      end
    end
    @(negedge clk); alloc_valid = 1'b0; merge_valid = 1'b0;
    #1;
    checks++;
    if (k != 16 || merge_ready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure got accepted=%0d ready=%b want 16/0", k, merge_ready);
    end
    do_merge(18, 17);
    end_frame(400, took);
    for (int i = 1; i <= 19; i++) do_lookup(i);
    do_lookup(41);
`ifdef CCL_MERGE_STATS_EN
    checks++;
    if (merge_count !== 16'd17 || fifo_hwm !== 5'd15) begin
      errors++;
      $display("FAIL stall_stats got mc=%0d hwm=%0d want 17/15", merge_count, fifo_hwm);
    end
`endif
  endtask

  task automatic test_exhaust();
    logic [7:0] e;
    @(negedge clk); frame_start4 = 1'b1;
    @(negedge clk); frame_start4 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); alloc_valid4 = 1'b1;
      exp_q.push_back((k < 14) ? 8'(k + 1) : 8'd0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({4'd0, alloc_label4} !== e) begin
        errors++;
        $display("FAIL w4_alloc_label[%0d] got %0d want %0d", k, alloc_label4, e);
      end
      if (k == 14) begin
        checks++;
        if (label_exhausted4 !== 1'b0) begin
          errors++;
          $display("FAIL w4_exhausted_early got %b want 0", label_exhausted4);
        end
      end
    end
    @(negedge clk); alloc_valid4 = 1'b0;
    #1;
    checks++;
    if (label_exhausted4 !== 1'b1 || num_labels4 !== 4'd15) begin
      errors++;
      $display("FAIL w4_exhausted got exh=%b num=%0d want 1/15", label_exhausted4, num_labels4);
    end
    checks++;
    if (merge_ready4 !== 1'b1 || proto_err4 !== 1'b0 || busy4 !== 1'b0 || flatten_done4 !== 1'b0 ||
        lookup_root4 !== 4'd0 || merge_count4 !== 16'd0 || fifo_hwm4 !== 5'd0) begin
      errors++;
      $display("FAIL w4_status got ready=%b perr=%b busy=%b done=%b root=%0d mc=%0d hwm=%0d want 1/0/0/0/0/0/0",
               merge_ready4, proto_err4, busy4, flatten_done4, lookup_root4, merge_count4, fifo_hwm4);
    end
  endtask

  task automatic test_reset_flatten();
    int saw;
    start_frame();
    do_alloc(10);
    do_merge(2, 1);
    @(negedge clk); eof = 1'b1;
    @(negedge clk); eof = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_busy got %b want 1", busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || num_labels !== 8'd1 || flatten_done !== 1'b0 || merge_ready !== 1'b0 || merge_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_flatten_reset got busy=%b num=%0d done=%b ready=%b mc=%0d want 0/1/0/0/0",
               busy, num_labels, flatten_done, merge_ready, merge_count);
    end
    @(negedge clk); reset_n = 1'b1;
    saw = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (flatten_done === 1'b1 || busy === 1'b1) saw++;
    end
    checks++;
    if (saw != 0) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d active cycles want 0", saw);
    end
  endtask

  initial begin
    test_reset();
    test_no_merge();
    test_proto_err();
    test_chain();
    test_conflict();
    test_back_to_back();
    test_exhaust();
    test_reset_flatten();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
